// File: rtl/sensor_spi_master.sv
// sensor_spi_master: serialises the 256-bit register image to the image sensor
// as 16-bit mode-0 SPI frames (R/W bit, 7-bit address, data byte) and returns
// each byte read from the sensor through a one-cycle FIFO write strobe.
module sensor_spi_master #(
  parameter int         NUM_REGS  = 32,
  parameter int         CLK_DIV   = 4,
  parameter int         CS_GAP    = 4,
  parameter logic [6:0] ADDR_BASE = 7'h00
) (
  input  logic         spi_clk,
  input  logic         rst_spi,
  input  logic         cmd_wr_sensor_spi,
  input  logic         cmd_rd_sensor_spi,
  input  logic [255:0] spi_register,
  output logic         sensor_spi_cs_n,
  output logic         sensor_spi_sclk,
  output logic         sensor_spi_mosi,
  input  logic         sensor_spi_miso,
  output logic         fifo_sensor_wen,
  output logic [7:0]   fifo_sensor_din,
  output logic         busy,
  output logic         done
);

  localparam int               CNT_MAX  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int               CNT_W    = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
  localparam logic [4:0]       LAST_IDX = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP,
    DONE
  } state_t;

  state_t             state;
  logic [2:0]         wr_sync;
  logic [2:0]         rd_sync;
  logic               wr_trig;
  logic               rd_trig;
  logic [255:0]       shadow;
  logic [4:0]         idx;
  logic [4:0]         next_idx;
  logic [7:0]         next_byte;
  logic               is_write;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         bit_cnt;
  logic [14:0]        tx_shift;
  logic [7:0]         rx_shift;
  logic [15:0]        start_frame;
  logic [15:0]        next_frame;

  // Frame layout: R/W flag, wrapped 7-bit address, data byte (zero for reads)
  function automatic logic [15:0] make_frame(input logic wr, input logic [4:0] index,
                                             input logic [7:0] data);
    logic [6:0] addr;
    addr = ADDR_BASE + {2'b00, index};
    return {wr, addr, (wr ? data : 8'h00)};
  endfunction

  // Command synchronisers; flops reset to 1 so a level held through reset cannot fire
  always_ff @(posedge spi_clk) begin
    if (rst_spi) begin
      wr_sync <= 3'b111;
      rd_sync <= 3'b111;
    end else begin
      wr_sync <= {wr_sync[1:0], cmd_wr_sensor_spi};
      rd_sync <= {rd_sync[1:0], cmd_rd_sensor_spi};
    end
  end

  assign wr_trig = wr_sync[1] & ~wr_sync[2];
  assign rd_trig = rd_sync[1] & ~rd_sync[2];

  assign next_idx    = idx + 5'd1;
  assign next_byte   = shadow[{next_idx, 3'b000} +: 8];
  assign start_frame = make_frame(wr_trig, 5'd0, spi_register[7:0]);
  assign next_frame  = make_frame(is_write, next_idx, next_byte);

  // Command sequencer and SPI shifter; every output is driven from this register set
  always_ff @(posedge spi_clk) begin
    if (rst_spi) begin
      state           <= IDLE;
      sensor_spi_cs_n <= 1'b1;
      sensor_spi_sclk <= 1'b0;
      sensor_spi_mosi <= 1'b0;
      fifo_sensor_wen <= 1'b0;
      fifo_sensor_din <= 8'h00;
      busy            <= 1'b0;
      done            <= 1'b0;
      shadow          <= '0;
      idx             <= '0;
      is_write        <= 1'b0;
      cnt             <= '0;
      bit_cnt         <= '0;
      tx_shift        <= '0;
      rx_shift        <= '0;
    end else begin
      fifo_sensor_wen <= 1'b0;
      done            <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (wr_trig || rd_trig) begin
            state           <= SETUP;
            shadow          <= spi_register;
            idx             <= '0;
            is_write        <= wr_trig;
            busy            <= 1'b1;
            sensor_spi_cs_n <= 1'b0;
            sensor_spi_sclk <= 1'b0;
            sensor_spi_mosi <= start_frame[15];
            tx_shift        <= start_frame[14:0];
            cnt             <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt             <= '0;
            state           <= SHIFT;
            sensor_spi_sclk <= 1'b1;
            rx_shift        <= {rx_shift[6:0], sensor_spi_miso};
            bit_cnt         <= 4'd15;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (sensor_spi_sclk) begin
              sensor_spi_sclk <= 1'b0;
              if (bit_cnt == 4'd0) begin
                state <= HOLD;
                if (!is_write) begin
                  fifo_sensor_wen <= 1'b1;
                  fifo_sensor_din <= rx_shift;
                end
              end else begin
                bit_cnt         <= bit_cnt - 1'b1;
                sensor_spi_mosi <= tx_shift[14];
                tx_shift        <= {tx_shift[13:0], 1'b0};
              end
            end else begin
              sensor_spi_sclk <= 1'b1;
              rx_shift        <= {rx_shift[6:0], sensor_spi_miso};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt             <= '0;
            state           <= GAP;
            sensor_spi_cs_n <= 1'b1;
            sensor_spi_mosi <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (idx != LAST_IDX) begin
              idx             <= next_idx;
              state           <= SETUP;
              sensor_spi_cs_n <= 1'b0;
              sensor_spi_mosi <= next_frame[15];
              tx_shift        <= next_frame[14:0];
            end else begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_spi_master.sv
// tb_sensor_spi_master: drives two instances (default parameters and a small
// wrap-around configuration) against a behavioural sensor and frame monitor.
module tb_sensor_spi_master;

  int n_checks = 0;
  int n_fail   = 0;

  logic spi_clk = 1'b0;
  logic rst_spi = 1'b1;

  logic         wr_a = 1'b0, rd_a = 1'b0;
  logic [255:0] reg_a = '0;
  logic         cs_n_a, sclk_a, mosi_a, wen_a, busy_a, done_a;
  logic         miso_a = 1'b0;
  logic [7:0]   din_a;

  logic         wr_b = 1'b0, rd_b = 1'b0;
  logic [255:0] reg_b = '0;
  logic         cs_n_b, sclk_b, mosi_b, wen_b, busy_b, done_b;
  logic         miso_b = 1'b0;
  logic [7:0]   din_b;

  // Clock generation
  always #5 spi_clk = ~spi_clk;

  sensor_spi_master dut_a (
    .spi_clk(spi_clk), .rst_spi(rst_spi),
    .cmd_wr_sensor_spi(wr_a), .cmd_rd_sensor_spi(rd_a), .spi_register(reg_a),
    .sensor_spi_cs_n(cs_n_a), .sensor_spi_sclk(sclk_a), .sensor_spi_mosi(mosi_a),
    .sensor_spi_miso(miso_a), .fifo_sensor_wen(wen_a), .fifo_sensor_din(din_a),
    .busy(busy_a), .done(done_a)
  );

  sensor_spi_master #(.NUM_REGS(3), .CLK_DIV(2), .CS_GAP(1), .ADDR_BASE(7'h7E)) dut_b (
    .spi_clk(spi_clk), .rst_spi(rst_spi),
    .cmd_wr_sensor_spi(wr_b), .cmd_rd_sensor_spi(rd_b), .spi_register(reg_b),
    .sensor_spi_cs_n(cs_n_b), .sensor_spi_sclk(sclk_b), .sensor_spi_mosi(mosi_b),
    .sensor_spi_miso(miso_b), .fifo_sensor_wen(wen_b), .fifo_sensor_din(din_b),
    .busy(busy_b), .done(done_b)
  );

  // Monitor and sensor model state, instance a
  logic [15:0] shin_a = '0;
  logic [7:0]  resp_a = '0;
  int          rises_a = 0, lowcnt_a = 0, hicnt_a = 0, dones_a = 0;
  logic [15:0] frames_a[$];
  int          cslow_a[$], gaps_a[$], wenpos_a[$];
  logic [7:0]  bytes_a[$];

  // Monitor and sensor model state, instance b
  logic [15:0] shin_b = '0;
  logic [7:0]  resp_b = '0;
  int          rises_b = 0, lowcnt_b = 0, hicnt_b = 0, dones_b = 0;
  logic [15:0] frames_b[$];
  int          cslow_b[$], gaps_b[$], wenpos_b[$];
  logic [7:0]  bytes_b[$];

  // Sensor a: captures MOSI on rising SCLK, answers 8'h10+addr in the data byte
  always @(negedge cs_n_a) begin rises_a = 0; shin_a = '0; end
  always @(posedge sclk_a) if (cs_n_a === 1'b0) begin
    shin_a = {shin_a[14:0], mosi_a};
    rises_a++;
    if (rises_a == 8) resp_a = 8'h10 + {1'b0, shin_a[6:0]};
  end
  always @(negedge sclk_a) begin
    if (cs_n_a === 1'b0 && rises_a >= 8 && rises_a < 16) miso_a = resp_a[3'(15 - rises_a)];
    else miso_a = 1'b0;
  end
  always @(posedge cs_n_a) if (rises_a > 0) frames_a.push_back(shin_a);

  // Sensor b: same behaviour as sensor a
  always @(negedge cs_n_b) begin rises_b = 0; shin_b = '0; end
  always @(posedge sclk_b) if (cs_n_b === 1'b0) begin
    shin_b = {shin_b[14:0], mosi_b};
    rises_b++;
    if (rises_b == 8) resp_b = 8'h10 + {1'b0, shin_b[6:0]};
  end
  always @(negedge sclk_b) begin
    if (cs_n_b === 1'b0 && rises_b >= 8 && rises_b < 16) miso_b = resp_b[3'(15 - rises_b)];
    else miso_b = 1'b0;
  end
  always @(posedge cs_n_b) if (rises_b > 0) frames_b.push_back(shin_b);

  // Cycle-level monitor a: CS low length, gap length, FIFO bytes and their position
  always @(negedge spi_clk) begin
    if (cs_n_a === 1'b0) begin
      if (wen_a === 1'b1) begin bytes_a.push_back(din_a); wenpos_a.push_back(lowcnt_a); end
      lowcnt_a++;
    end else begin
      if (wen_a === 1'b1) begin bytes_a.push_back(din_a); wenpos_a.push_back(-1); end
      if (lowcnt_a > 0) cslow_a.push_back(lowcnt_a);
      lowcnt_a = 0;
    end
    if (busy_a === 1'b1 && cs_n_a === 1'b1) hicnt_a++;
    else if (busy_a === 1'b1 && hicnt_a > 0) begin gaps_a.push_back(hicnt_a); hicnt_a = 0; end
    else if (busy_a !== 1'b1) hicnt_a = 0;
    if (done_a === 1'b1) dones_a++;
  end

  // Cycle-level monitor b
  always @(negedge spi_clk) begin
    if (cs_n_b === 1'b0) begin
      if (wen_b === 1'b1) begin bytes_b.push_back(din_b); wenpos_b.push_back(lowcnt_b); end
      lowcnt_b++;
    end else begin
      if (wen_b === 1'b1) begin bytes_b.push_back(din_b); wenpos_b.push_back(-1); end
      if (lowcnt_b > 0) cslow_b.push_back(lowcnt_b);
      lowcnt_b = 0;
    end
    if (busy_b === 1'b1 && cs_n_b === 1'b1) hicnt_b++;
    else if (busy_b === 1'b1 && hicnt_b > 0) begin gaps_b.push_back(hicnt_b); hicnt_b = 0; end
    else if (busy_b !== 1'b1) hicnt_b = 0;
    if (done_b === 1'b1) dones_b++;
  end

  task automatic clear_mon();
    frames_a.delete(); cslow_a.delete(); gaps_a.delete(); bytes_a.delete(); wenpos_a.delete();
    frames_b.delete(); cslow_b.delete(); gaps_b.delete(); bytes_b.delete(); wenpos_b.delete();
    dones_a = 0; dones_b = 0;
  endtask

  task automatic rand_image(output logic [255:0] img);
    for (int k = 0; k < 8; k++) img[32*k +: 32] = $urandom;
  endtask

  // Waits for done on the selected instance; cyc = negedges waited, -1 on timeout
  task automatic wait_done(input bit sel, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget && cyc < 0; i++) begin
      @(negedge spi_clk);
      if ((sel ? done_b : done_a) === 1'b1) cyc = i;
    end
  endtask

  task automatic test_reset();
    rst_spi = 1'b1;
    repeat (4) @(negedge spi_clk);
    n_checks++;
    if ({cs_n_a, sclk_a, mosi_a, wen_a, busy_a, done_a} !== 6'b100000) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs_a: got %b, expected 100000",
               {cs_n_a, sclk_a, mosi_a, wen_a, busy_a, done_a});
    end
    n_checks++;
    if (din_a !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_din_a: got %h, expected 00", din_a); end
    n_checks++;
    if ({cs_n_b, sclk_b, busy_b, done_b} !== 4'b1000) begin
      n_fail++; $display("[TB] FAIL reset_outputs_b: got %b, expected 1000", {cs_n_b, sclk_b, busy_b, done_b});
    end
    rst_spi = 1'b0;
    repeat (6) @(negedge spi_clk);
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_release_idle: busy=%b, expected 0", busy_a); end
  endtask

  task automatic test_write();
    logic [255:0] img;
    logic [15:0]  exp_f, got_f;
    int           cyc;
    rand_image(img);
    img[7:0] = 8'hA5; img[15:8] = 8'h3C;
    clear_mon(); reg_a = img;
    @(negedge spi_clk); wr_a = 1'b1;
    repeat (2) @(negedge spi_clk);
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_accept_early: busy=%b, expected 0", busy_a); end
    @(negedge spi_clk);
    n_checks++;
    if ({busy_a, cs_n_a} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL wr_accept: busy,cs_n=%b, expected 10", {busy_a, cs_n_a});
    end
    wr_a = 1'b0;
    wait_done(1'b0, 5000, cyc);
    n_checks++;
    if (cyc != 4352) begin n_fail++; $display("[TB] FAIL wr_done_time: got %0d, expected 4352", cyc); end
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_busy_drop: busy=%b, expected 0", busy_a); end
    repeat (20) @(negedge spi_clk);
    n_checks++;
    if (frames_a.size() != 32) begin n_fail++; $display("[TB] FAIL wr_frame_count: got %0d, expected 32", frames_a.size()); end
    got_f = (frames_a.size() > 1) ? frames_a[0] : 16'hFFFF;
    n_checks++;
    if (got_f !== 16'h80A5) begin n_fail++; $display("[TB] FAIL wr_frame0: got %h, expected 80a5", got_f); end
    got_f = (frames_a.size() > 1) ? frames_a[1] : 16'hFFFF;
    n_checks++;
    if (got_f !== 16'h813C) begin n_fail++; $display("[TB] FAIL wr_frame1: got %h, expected 813c", got_f); end
    for (int k = 0; k < 32; k++) begin
      exp_f = {1'b1, 7'(k), img[8*k +: 8]};
      got_f = (k < frames_a.size()) ? frames_a[k] : 16'hFFFF;
      n_checks++;
      if (got_f !== exp_f) begin n_fail++; $display("[TB] FAIL wr_frame[%0d]: got %h, expected %h", k, got_f, exp_f); end
      n_checks++;
      if (((k < cslow_a.size()) ? cslow_a[k] : -1) != 132) begin
        n_fail++; $display("[TB] FAIL wr_cs_low[%0d]: got %0d, expected 132", k, (k < cslow_a.size()) ? cslow_a[k] : -1);
      end
    end
    n_checks++;
    if (gaps_a.size() != 31) begin n_fail++; $display("[TB] FAIL wr_gap_count: got %0d, expected 31", gaps_a.size()); end
    foreach (gaps_a[k]) begin
      n_checks++;
      if (gaps_a[k] != 4) begin n_fail++; $display("[TB] FAIL wr_gap[%0d]: got %0d, expected 4", k, gaps_a[k]); end
    end
    n_checks++;
    if (bytes_a.size() != 0) begin n_fail++; $display("[TB] FAIL wr_no_wen: got %0d strobes, expected 0", bytes_a.size()); end
    n_checks++;
    if (dones_a != 1) begin n_fail++; $display("[TB] FAIL wr_done_pulses: got %0d, expected 1", dones_a); end
  endtask

  task automatic test_read();
    logic [15:0] exp_f, got_f;
    logic [7:0]  exp_b, got_b;
    int          cyc;
    clear_mon();
    @(negedge spi_clk); rd_a = 1'b1;
    wait_done(1'b0, 5000, cyc);
    rd_a = 1'b0;
    n_checks++;
    if (cyc != 4355) begin n_fail++; $display("[TB] FAIL rd_done_time: got %0d, expected 4355", cyc); end
    repeat (10) @(negedge spi_clk);
    n_checks++;
    if (bytes_a.size() != 32) begin n_fail++; $display("[TB] FAIL rd_byte_count: got %0d, expected 32", bytes_a.size()); end
    for (int k = 0; k < 32; k++) begin
      exp_b = 8'h10 + 8'(k);
      got_b = (k < bytes_a.size()) ? bytes_a[k] : 8'hFF;
      n_checks++;
      if (got_b !== exp_b) begin n_fail++; $display("[TB] FAIL rd_byte[%0d]: got %h, expected %h", k, got_b, exp_b); end
      n_checks++;
      if (((k < wenpos_a.size()) ? wenpos_a[k] : -2) != 128) begin
        n_fail++; $display("[TB] FAIL rd_wen_pos[%0d]: got %0d, expected 128", k, (k < wenpos_a.size()) ? wenpos_a[k] : -2);
      end
      exp_f = {1'b0, 7'(k), 8'h00};
      got_f = (k < frames_a.size()) ? frames_a[k] : 16'hFFFF;
      n_checks++;
      if (got_f !== exp_f) begin n_fail++; $display("[TB] FAIL rd_frame[%0d]: got %h, expected %h", k, got_f, exp_f); end
    end
  endtask

  task automatic test_collision();
    logic [255:0] img;
    logic [15:0]  exp_f, got_f;
    int           cyc;
    bit           went;
    rand_image(img);
    clear_mon(); reg_a = img;
    @(negedge spi_clk); wr_a = 1'b1; rd_a = 1'b1;
    repeat (20) @(negedge spi_clk);
    wr_a = 1'b0; rd_a = 1'b0;
    repeat (50) @(negedge spi_clk);
    rd_a = 1'b1;
    wait_done(1'b0, 5000, cyc);
    n_checks++;
    if (cyc < 0) begin n_fail++; $display("[TB] FAIL col_done_timeout: got %0d, expected done", cyc); end
    went = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge spi_clk);
      if (i == 20) rd_a = 1'b0;
      if (busy_a !== 1'b0) went = 1'b1;
    end
    n_checks++;
    if (went) begin n_fail++; $display("[TB] FAIL col_read_dropped: busy rose again, expected idle"); end
    n_checks++;
    if (dones_a != 1) begin n_fail++; $display("[TB] FAIL col_done_pulses: got %0d, expected 1", dones_a); end
    n_checks++;
    if (bytes_a.size() != 0) begin n_fail++; $display("[TB] FAIL col_no_wen: got %0d, expected 0", bytes_a.size()); end
    n_checks++;
    if (frames_a.size() != 32) begin n_fail++; $display("[TB] FAIL col_frame_count: got %0d, expected 32", frames_a.size()); end
    for (int k = 0; k < 32; k++) begin
      exp_f = {1'b1, 7'(k), img[8*k +: 8]};
      got_f = (k < frames_a.size()) ? frames_a[k] : 16'hFFFF;
      n_checks++;
      if (got_f !== exp_f) begin n_fail++; $display("[TB] FAIL col_frame[%0d]: got %h, expected %h", k, got_f, exp_f); end
    end
  endtask

  task automatic test_snapshot();
    logic [255:0] img, noise;
    logic [15:0]  exp_f, got_f;
    int           cyc;
    rand_image(img);
    clear_mon(); reg_a = img;
    @(negedge spi_clk); wr_a = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 5000 && cyc < 0; i++) begin
      @(negedge spi_clk);
      if (i == 4) wr_a = 1'b0;
      if (i >= 5 && (i % 37) == 0) begin rand_image(noise); reg_a = noise; end
      if (done_a === 1'b1) cyc = i;
    end
    n_checks++;
    if (cyc != 4355) begin n_fail++; $display("[TB] FAIL snap_done_time: got %0d, expected 4355", cyc); end
    repeat (10) @(negedge spi_clk);
    for (int k = 0; k < 32; k++) begin
      exp_f = {1'b1, 7'(k), img[8*k +: 8]};
      got_f = (k < frames_a.size()) ? frames_a[k] : 16'hFFFF;
      n_checks++;
      if (got_f !== exp_f) begin n_fail++; $display("[TB] FAIL snap_frame[%0d]: got %h, expected %h", k, got_f, exp_f); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got_f;
    logic [7:0]  got_b;
    int          cyc;
    bit          found, went;
    clear_mon();
    @(negedge spi_clk); rd_a = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge spi_clk);
      if (frames_a.size() == 5 && rises_a == 7 && cs_n_a === 1'b0) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("[TB] FAIL rst_reach_bit9: got not reached, expected frame 5 bit 9"); end
    rst_spi = 1'b1;
    @(negedge spi_clk);
    n_checks++;
    if ({cs_n_a, sclk_a, busy_a, wen_a, done_a} !== 5'b10000) begin
      n_fail++; $display("[TB] FAIL rst_mid_outputs: got %b, expected 10000", {cs_n_a, sclk_a, busy_a, wen_a, done_a});
    end
    repeat (3) @(negedge spi_clk);
    rst_spi = 1'b0;
    went = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge spi_clk);
      if (busy_a !== 1'b0 || cs_n_a !== 1'b1) went = 1'b1;
    end
    n_checks++;
    if (went) begin n_fail++; $display("[TB] FAIL rst_no_retrigger: command restarted, expected idle"); end
    n_checks++;
    if (bytes_a.size() != 5) begin n_fail++; $display("[TB] FAIL rst_no_partial_wen: got %0d, expected 5", bytes_a.size()); end
    rd_a = 1'b0;
    repeat (4) @(negedge spi_clk);
    clear_mon();
    rd_a = 1'b1;
    wait_done(1'b0, 5000, cyc);
    rd_a = 1'b0;
    n_checks++;
    if (cyc != 4355) begin n_fail++; $display("[TB] FAIL restart_done_time: got %0d, expected 4355", cyc); end
    repeat (10) @(negedge spi_clk);
    got_f = (frames_a.size() > 0) ? frames_a[0] : 16'hFFFF;
    n_checks++;
    if (got_f !== 16'h0000) begin n_fail++; $display("[TB] FAIL restart_frame0: got %h, expected 0000", got_f); end
    got_b = (bytes_a.size() == 32) ? bytes_a[31] : 8'hFF;
    n_checks++;
    if (got_b !== 8'h2F) begin n_fail++; $display("[TB] FAIL restart_last_byte: got %h, expected 2f", got_b); end
  endtask

  task automatic test_params();
    logic [255:0] img;
    logic [15:0]  exp_f, got_f;
    logic [7:0]   exp_b, got_b;
    logic [6:0]   addr;
    int           cyc;
    rand_image(img);
    clear_mon(); reg_b = img;
    @(negedge spi_clk); wr_b = 1'b1;
    repeat (3) @(negedge spi_clk);
    n_checks++;
    if ({busy_b, cs_n_b} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL p_accept: busy,cs_n=%b, expected 10", {busy_b, cs_n_b});
    end
    wr_b = 1'b0;
    wait_done(1'b1, 500, cyc);
    n_checks++;
    if (cyc != 201) begin n_fail++; $display("[TB] FAIL p_wr_done_time: got %0d, expected 201", cyc); end
    repeat (10) @(negedge spi_clk);
    n_checks++;
    if (frames_b.size() != 3) begin n_fail++; $display("[TB] FAIL p_frame_count: got %0d, expected 3", frames_b.size()); end
    for (int k = 0; k < 3; k++) begin
      addr  = 7'h7E + 7'(k);
      exp_f = {1'b1, addr, img[8*k +: 8]};
      got_f = (k < frames_b.size()) ? frames_b[k] : 16'hFFFF;
      n_checks++;
      if (got_f !== exp_f) begin n_fail++; $display("[TB] FAIL p_wr_frame[%0d]: got %h, expected %h", k, got_f, exp_f); end
      n_checks++;
      if (((k < cslow_b.size()) ? cslow_b[k] : -1) != 66) begin
        n_fail++; $display("[TB] FAIL p_cs_low[%0d]: got %0d, expected 66", k, (k < cslow_b.size()) ? cslow_b[k] : -1);
      end
    end
    n_checks++;
    if (gaps_b.size() != 2 || gaps_b[0] != 1 || gaps_b[1] != 1) begin
      n_fail++; $display("[TB] FAIL p_gaps: got %0d gaps, expected 2 gaps of 1", gaps_b.size());
    end
    clear_mon();
    @(negedge spi_clk); rd_b = 1'b1;
    wait_done(1'b1, 500, cyc);
    rd_b = 1'b0;
    n_checks++;
    if (cyc != 204) begin n_fail++; $display("[TB] FAIL p_rd_done_time: got %0d, expected 204", cyc); end
    repeat (10) @(negedge spi_clk);
    n_checks++;
    if (bytes_b.size() != 3) begin n_fail++; $display("[TB] FAIL p_byte_count: got %0d, expected 3", bytes_b.size()); end
    for (int k = 0; k < 3; k++) begin
      addr  = 7'h7E + 7'(k);
      exp_b = 8'h10 + {1'b0, addr};
      got_b = (k < bytes_b.size()) ? bytes_b[k] : 8'hFF;
      n_checks++;
      if (got_b !== exp_b) begin n_fail++; $display("[TB] FAIL p_rd_byte[%0d]: got %h, expected %h", k, got_b, exp_b); end
      n_checks++;
      if (((k < wenpos_b.size()) ? wenpos_b[k] : -2) != 64) begin
        n_fail++; $display("[TB] FAIL p_wen_pos[%0d]: got %0d, expected 64", k, (k < wenpos_b.size()) ? wenpos_b[k] : -2);
      end
    end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_write();
    repeat ($urandom_range(3, 20)) @(negedge spi_clk);
    test_read();
    repeat ($urandom_range(3, 20)) @(negedge spi_clk);
    test_collision();
    repeat ($urandom_range(3, 20)) @(negedge spi_clk);
    test_snapshot();
    repeat ($urandom_range(3, 20)) @(negedge spi_clk);
    test_reset_mid();
    repeat ($urandom_range(3, 20)) @(negedge spi_clk);
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_spi_master.md
# sensor_spi_master

Sensor configuration SPI master on the `spi_clk` domain. It consumes the write/read command strobes and the 256-bit `spi_register` image produced by the Camera Link protocol decoder, and serialises register frames to the image sensor. On reads it returns each sensor byte through the `fifo_sensor_wen`/`fifo_sensor_din` port, which feeds the serial response FIFO back to the Camera Link host.

## Interface

Parameters:
- `NUM_REGS`, default 32: registers per command (1..32); register i = `spi_register[8i+7:8i]`.
- `CLK_DIV`, default 4: SCLK half-period in `spi_clk` cycles (>= 2).
- `CS_GAP`, default 4: cycles `sensor_spi_cs_n` stays high between frames (>= 1).
- `ADDR_BASE`, default 0: 7-bit sensor address of register 0.

Ports:
- `spi_clk` in 1: the only clock.
- `rst_spi` in 1: synchronous, active-high reset.
- `cmd_wr_sensor_spi` in 1: write-all request, level from `clk_fix` domain; rising edge triggers.
- `cmd_rd_sensor_spi` in 1: read-all request, same rules.
- `spi_register` in 256: register image; snapshot at command accept.
- `sensor_spi_cs_n` out 1: chip select, active low.
- `sensor_spi_sclk` out 1: serial clock, idle low (mode 0).
- `sensor_spi_mosi` out 1: serial data to sensor.
- `sensor_spi_miso` in 1: serial data from sensor.
- `fifo_sensor_wen` out 1: one-cycle write strobe, read byte valid.
- `fifo_sensor_din` out 8: read byte.
- `busy` out 1: high from accept until `done`.
- `done` out 1: one-cycle pulse at command completion.

## Operation

- Command inputs pass a 2-flop synchroniser plus a third flop; trigger = sync2 & ~sync3. All three flops reset to 1, so a command held high through reset does not fire.
- Triggers arriving while `busy` are dropped. Simultaneous wr and rd triggers: write executes, read is dropped.
- On accept: latch `spi_register` into a 256-bit shadow, set reg index i=0, set `busy`.
- Frame (16 bits, MSB first): bit15 = 1 for write / 0 for read, bits14:8 = `ADDR_BASE + i` (7-bit wrap), bits7:0 = shadow byte i for write / 8'h00 for read.
- FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> (SETUP if i < NUM_REGS-1, i++) | DONE -> IDLE.
  - SETUP: CLK_DIV cycles; cs_n=0, sclk=0, mosi=bit15.
  - SHIFT: 16 bits, each a high phase then a low phase of CLK_DIV cycles. MOSI updates to the next bit at each falling edge. MISO is registered on the cycle SCLK rises.
  - HOLD: the low phase after bit0. In its first cycle, a read frame pulses `fifo_sensor_wen` with the captured MISO bits7:0 (first-sampled bit = MSB).
  - GAP: cs_n=1, sclk=0, CS_GAP cycles.
  - DONE: one cycle, `done`=1, then `busy`=0.
- Bytes are written in ascending address order, one per frame. No back-pressure: the downstream FIFO is sized for 32 bytes.

## Timing

- Reset values: cs_n=1, sclk=0, mosi=0, wen=0, din=8'h00, busy=0, done=0, FSM=IDLE.
- Reset mid-operation: the next cycle shows reset values. The partial frame is aborted with no FIFO write, and the shadow/index are cleared.
- Accept latency: cmd first sampled high at edge N; cs_n low and busy high after edge N+2.
- CS low per frame: 33*CLK_DIV cycles. Frame period: 33*CLK_DIV + CS_GAP.
- With defaults: 136 cycles/frame, 32 frames = 4352 cycles. `done` pulses 1 cycle after the last GAP; busy drops in the same cycle.
- SCLK frequency = spi_clk / (2*CLK_DIV). All outputs are registered, with no combinational input-to-output path.
- `spi_register` changes during a command have no effect on the frames being sent.

## Test plan

- Write, defaults, `spi_register[7:0]`=8'hA5, `[15:8]`=8'h3C: 32 frames. Frame 0 MOSI = 16'h80A5, frame 1 = 16'h813C. cs_n low 132 cycles, high 4. done after 4352 cycles. No wen.
- Read, sensor model returns 8'h10+addr: 32 wen pulses with din 8'h10..8'h2F in order. Each pulse comes in the first HOLD cycle. Frame 0 MOSI = 16'h0000.
- Wr and rd rising in the same cycle, then rd again while busy: only write frames (bit15=1) are sent. Both read triggers are dropped and done pulses once.
- Change `spi_register` mid-write: all 32 frames carry the snapshot values.
- Assert `rst_spi` during frame 5 bit 9: next cycle cs_n=1, sclk=0, busy=0, no wen. Cmd held high across reset gives no retrigger; a low-high toggle restarts at addr 0.
- Parameters NUM_REGS=3, CLK_DIV=2, CS_GAP=1, ADDR_BASE=7'h7E: addresses 7E, 7F, 00 (wrap). 67 cycles/frame. Read returns 3 bytes.
